mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single backing-memory port between two requesters: instruction-fetch refill (I side) and data-cache miss/write-through (D side).
- Sequences each access over a fixed multi-cycle memory latency.
- Returns read data to the winning requester.
- Drives a busy flag to the hazard unit, which uses it to stall the pipeline.

Parameters:
- ADDR_W, 32, address width of requests and memory port
- DATA_W, 32, data width of requests and memory port
- MEM_LAT, 2, cycles mem_en is held per access (legal range 1..15)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- i_req  in  1  I-side read request; held until i_rvalid
- i_addr  in  ADDR_W  I-side byte address
- i_gnt  out  1  one-cycle pulse: I request accepted
- i_rvalid  out  1  one-cycle pulse: i_rdata valid
- i_rdata  out  DATA_W  I-side read data
- d_req  in  1  D-side request; held until d_rvalid
- d_we  in  1  D-side write (1) / read (0)
- d_addr  in  ADDR_W  D-side byte address
- d_wdata  in  DATA_W  D-side write data
- d_gnt  out  1  one-cycle pulse: D request accepted
- d_rvalid  out  1  one-cycle pulse: D read data valid or write complete
- d_rdata  out  DATA_W  D-side read data; 0 on write completion
- mem_en  out  1  memory access active
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid on the last mem_en cycle
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: while rst is low, state = IDLE and every output = 0, asynchronously (mem_en drops immediately). An access interrupted by reset is abandoned with no rvalid. Reset release is synchronous to clk.
- All outputs are registered. The FSM has three states: IDLE, ACCESS, RESP.
- IDLE:
  - Samples i_req and d_req at the rising edge.
  - If any request is present: pulse the winner's gnt for the next cycle, capture owner/addr/we/wdata, load counter = MEM_LAT, go to ACCESS.
  - No request: stay in IDLE with all outputs 0.
- Arbitration, default: fixed priority, D over I, because the D access belongs to an older instruction. The loser keeps req high and is serviced on the next IDLE.
- ACCESS:
  - mem_en = 1; mem_addr, mem_we and mem_wdata are taken from the captured values, stable for exactly MEM_LAT cycles.
  - The counter decrements each cycle. On the cycle counter == 1, mem_rdata is latched (read) and the FSM moves to RESP.
- RESP:
  - mem_en = 0.
  - Owner's rvalid = 1 for exactly one cycle. rdata = latched data for a read, 0 for a write.
  - The non-owner's rvalid and rdata stay 0. Next state is IDLE.
  - rdata holds its value until the next rvalid for that side.
- Timing:
  - Request seen at edge N: gnt during cycle N+1; mem_en during cycles N+1..N+MEM_LAT; rvalid during cycle N+MEM_LAT+1.
  - Back-to-back accesses are spaced MEM_LAT+2 cycles (the IDLE cycle is mandatory).
- Requester rules:
  - Requester drops req no later than the cycle after its rvalid.
  - A req still high in IDLE is treated as a new request.
- req deasserted mid-access: ignored; the access completes and rvalid still pulses.
- Changes to addr/wdata after gnt are ignored, since the values were captured at grant.
- Both requests arriving on the same edge are resolved by the arbitration rule. Exactly one gnt is ever high.
- Counter width is 4 bits. MEM_LAT outside 1..15 is a fatal elaboration error.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit last_owner register (reset 0 = D) sets priority on simultaneous requests; the side that did not own the last access wins. A lone requester always wins regardless of last_owner. last_owner updates at every grant.
- Undefined: fixed D-over-I priority; no last_owner register is built.

Test Plan:
- Single I read:
  - Stimulus: MEM_LAT=2, i_req with i_addr=0x100, mem_rdata=0xDEADBEEF.
  - Response: i_gnt at +1; mem_en for 2 cycles with mem_addr=0x100, mem_we=0; i_rvalid at +3 with i_rdata=0xDEADBEEF; busy high for 3 cycles.
- D write:
  - Stimulus: d_we=1, d_addr=0x40, d_wdata=0x12345678.
  - Response: mem_we=1 and mem_wdata=0x12345678 for 2 cycles; d_rvalid at +3 with d_rdata=0; i_rvalid stays 0.
- Simultaneous requests, macro off:
  - Stimulus: i_req and d_req on the same edge.
  - Response: D is served first (d_rvalid at +3); I is granted at +5 (after the mandatory IDLE cycle) and i_rvalid arrives at +7.
- Round-robin, macro on:
  - Stimulus: 4 consecutive simultaneous request pairs.
  - Response: owners alternate I, D, I, D. This starts with I because last_owner resets to D.
- Reset mid-access:
  - Stimulus: rst low during the 2nd ACCESS cycle.
  - Response: mem_en=0 and busy=0 immediately; no rvalid; after release, a fresh i_req completes normally.
- Latency sweep:
  - Stimulus: MEM_LAT=1 and MEM_LAT=15.
  - Response: mem_en width = 1 and 15 cycles; rvalid at +2 and +16 respectively.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one backing-memory port between the instruction-fetch
//             refill side (I) and the data-cache miss / write-through side
//             (D). Each access holds mem_en for MEM_LAT cycles, then the read
//             data (or a write completion) is returned to the owner with a
//             one-cycle rvalid pulse. busy is high whenever the arbiter is
//             not idle, so the hazard unit can stall the pipeline.
//
//  Ports    : clk, rst (asynchronous, active-low)
//             i_req/i_addr            -> i_gnt/i_rvalid/i_rdata
//             d_req/d_we/d_addr/d_wdata -> d_gnt/d_rvalid/d_rdata
//             mem_en/mem_we/mem_addr/mem_wdata -> memory, mem_rdata <- memory
//             busy                    -> hazard unit
//
//  Options  : `define ARB_ROUND_ROBIN_EN gives simultaneous requests to the
//             side that did not own the previous access. Without it, D
//             always beats I (the D access belongs to an older instruction).
//
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    // I side (read only)
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    // D side (read or write)
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    // Memory port
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    // Stall request
    output logic              busy
);

    // The latency counter is 4 bits wide, so only 1..15 can be represented.
    generate
        if ((MEM_LAT < 1) || (MEM_LAT > 15)) begin : g_bad_mem_lat
            $fatal(1, "mem_port_arbiter: MEM_LAT must be in 1..15");
        end
    endgenerate

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_access = 2'd1;
    localparam logic [1:0] c_st_resp   = 2'd2;
    localparam logic [3:0] c_lat       = 4'(MEM_LAT);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [3:0]        r_cnt;
    logic              r_owner_i;     // 1: current access belongs to I
    logic              w_start;       // a grant happens at this edge
    logic              w_last_beat;   // final mem_en cycle of the access
    logic              w_pick_i;      // winner if a grant happens now

    logic              r_i_gnt;
    logic              r_i_rvalid;
    logic [DATA_W-1:0] r_i_rdata;
    logic              r_d_gnt;
    logic              r_d_rvalid;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_busy;

    // ------------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------------
`ifdef ARB_ROUND_ROBIN_EN
    // 0 = D owned the last access, 1 = I owned it. A lone requester always
    // wins; on a tie the side that did not own the last access wins.
    logic r_last_owner_i;

    assign w_pick_i = i_req & (~d_req | ~r_last_owner_i);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_owner_i <= 1'b0;
        end else if (w_start) begin
            r_last_owner_i <= w_pick_i;
        end
    end
`else
    assign w_pick_i = i_req & ~d_req;
`endif

    // ------------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------------
    assign w_last_beat = (r_cnt == 4'd1);

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (i_req || d_req) begin
                    w_start     = 1'b1;
                    w_state_nxt = c_st_access;
                end
            end
            c_st_access: begin
                if (w_last_beat) begin
                    w_state_nxt = c_st_resp;
                end
            end
            c_st_resp: begin
                // Returning to IDLE unconditionally gives the mandatory idle
                // cycle between back-to-back accesses.
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Registered datapath and outputs. The memory-side registers double as the
    // capture of the winning request, so later changes on the request
    // buses have no effect on an access in flight.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= 4'd0;
            r_owner_i   <= 1'b0;
            r_i_gnt     <= 1'b0;
            r_i_rvalid  <= 1'b0;
            r_i_rdata   <= '0;
            r_d_gnt     <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_d_rdata   <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
        end else begin
            // Handshake pulses default low; each is raised for one cycle only.
            r_i_gnt    <= 1'b0;
            r_d_gnt    <= 1'b0;
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_start) begin
                        r_owner_i   <= w_pick_i;
                        r_i_gnt     <= w_pick_i;
                        r_d_gnt     <= ~w_pick_i;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= ~w_pick_i & d_we;
                        r_mem_addr  <= w_pick_i ? i_addr : d_addr;
                        // I side never writes; drive zero rather than stale data.
                        r_mem_wdata <= w_pick_i ? '0 : d_wdata;
                        r_cnt       <= c_lat;
                        r_busy      <= 1'b1;
                    end
                end
                c_st_access: begin
                    if (w_last_beat) begin
                        r_mem_en    <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= '0;
                        r_mem_wdata <= '0;
                        // rdata is only updated here, so each side holds its
                        // last returned value until its next rvalid.
                        if (r_owner_i) begin
                            r_i_rvalid <= 1'b1;
                            r_i_rdata  <= mem_rdata;
                        end else begin
                            r_d_rvalid <= 1'b1;
                            r_d_rdata  <= r_mem_we ? '0 : mem_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_st_resp: begin
                    r_busy <= 1'b0;
                end
                default: begin
                    r_busy   <= 1'b0;
                    r_mem_en <= 1'b0;
                end
            endcase
        end
    end

    assign i_gnt     = r_i_gnt;
    assign i_rvalid  = r_i_rvalid;
    assign i_rdata   = r_i_rdata;
    assign d_gnt     = r_d_gnt;
    assign d_rvalid  = r_d_rvalid;
    assign d_rdata   = r_d_rdata;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Self-checking bench for mem_port_arbiter. Directed scenarios
//             plus a randomized run checked against a cycle-timing model of
//             the arbiter (grant edge, access window, response cycle).
//             Two extra instances cover MEM_LAT = 1 and MEM_LAT = 15.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        mem_force;
    logic [31:0] mem_force_val;
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;

    // Main instance (MEM_LAT = 2)
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    // Latency sweep instances
    logic        s1_i_gnt, s1_i_rvalid, s1_d_gnt, s1_d_rvalid, s1_mem_en, s1_mem_we, s1_busy;
    logic [31:0] s1_i_rdata, s1_d_rdata, s1_mem_addr, s1_mem_wdata, s1_mem_rdata;
    logic        s15_i_gnt, s15_i_rvalid, s15_d_gnt, s15_d_rvalid, s15_mem_en, s15_mem_we, s15_busy;
    logic [31:0] s15_i_rdata, s15_d_rdata, s15_mem_addr, s15_mem_wdata, s15_mem_rdata;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents change every cycle so that sampling on the wrong cycle
    // returns a different word.
    function automatic logic [31:0] mem_fn(input logic [31:0] a, input int c);
        return a ^ (32'(c) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign mem_rdata     = mem_force ? mem_force_val : mem_fn(mem_addr, cyc);
    assign s1_mem_rdata  = mem_force ? mem_force_val : mem_fn(s1_mem_addr, cyc);
    assign s15_mem_rdata = mem_force ? mem_force_val : mem_fn(s15_mem_addr, cyc);

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L)) u_dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(s1_i_gnt), .i_rvalid(s1_i_rvalid), .i_rdata(s1_i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(s1_d_gnt), .d_rvalid(s1_d_rvalid), .d_rdata(s1_d_rdata),
        .mem_en(s1_mem_en), .mem_we(s1_mem_we), .mem_addr(s1_mem_addr), .mem_wdata(s1_mem_wdata),
        .mem_rdata(s1_mem_rdata), .busy(s1_busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(15)) u_lat15 (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(s15_i_gnt), .i_rvalid(s15_i_rvalid), .i_rdata(s15_i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(s15_d_gnt), .d_rvalid(s15_d_rvalid), .d_rdata(s15_d_rdata),
        .mem_en(s15_mem_en), .mem_we(s15_mem_we), .mem_addr(s15_mem_addr), .mem_wdata(s15_mem_wdata),
        .mem_rdata(s15_mem_rdata), .busy(s15_busy)
    );

    // Reset with idle inputs; returns 1 time unit after the releasing edge.
    task automatic do_reset();
        rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_force = 1'b0; mem_force_val = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; i_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
        i_addr = 32'h1; d_addr = 32'h2; d_wdata = 32'h3; mem_force = 1'b0; mem_force_val = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got gnt=%b%b rv=%b%b en=%b we=%b busy=%b addr=%h wd=%h ir=%h dr=%h, want all 0",
                     i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en, mem_we, busy, mem_addr, mem_wdata, i_rdata, d_rdata);
        end
        checks++;
        if ({s1_i_gnt, s1_i_rvalid, s1_i_rdata, s1_d_gnt, s1_d_rvalid, s1_d_rdata, s1_mem_en, s1_mem_we,
             s1_mem_addr, s1_mem_wdata, s1_busy, s15_i_gnt, s15_i_rvalid, s15_i_rdata, s15_d_gnt, s15_d_rvalid,
             s15_d_rdata, s15_mem_en, s15_mem_we, s15_mem_addr, s15_mem_wdata, s15_busy} !== '0) begin
            errors++;
            $display("FAIL reset_sweep_outputs: got busy1=%b busy15=%b en1=%b en15=%b, want all 0",
                     s1_busy, s15_busy, s1_mem_en, s15_mem_en);
        end
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({mem_en, busy, i_gnt, d_gnt} !== 4'b0) begin
                errors++;
                $display("FAIL idle_no_req: got en=%b busy=%b gnt=%b%b, want 0", mem_en, busy, i_gnt, d_gnt);
            end
        end
    endtask

    task automatic test_single_i_read();
        logic [6:0]  got, exp;
        logic [31:0] ea, er;
        @(posedge clk); #1;
        mem_force = 1'b1; mem_force_val = 32'hDEAD_BEEF;
        i_req = 1'b1; i_addr = 32'h100;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (k == 3) i_req = 1'b0;
            @(negedge clk);
            got = {i_gnt, d_gnt, mem_en, mem_we, i_rvalid, d_rvalid, busy};
            exp = {k == 0, 1'b0, k <= 1, 1'b0, k == 2, 1'b0, k <= 2};
            ea  = (k <= 1) ? 32'h100 : 32'h0;
            er  = (k >= 2) ? 32'hDEAD_BEEF : 32'h0;
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL i_read_ctrl k=%0d: got %b want %b (gnt_i,gnt_d,en,we,rv_i,rv_d,busy)", k, got, exp);
            end
            checks++;
            if (mem_addr !== ea || i_rdata !== er) begin
                errors++;
                $display("FAIL i_read_data k=%0d: got addr=%h rdata=%h want addr=%h rdata=%h", k, mem_addr, i_rdata, ea, er);
            end
        end
        mem_force = 1'b0;
    endtask

`ifdef ARB_ROUND_ROBIN_EN
    task automatic test_round_robin();
        logic [1:0] got, exp;
        do_reset();
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; i_addr = 32'h10; d_addr = 32'h20;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            if (k == 15) begin i_req = 1'b0; d_req = 1'b0; end
            @(negedge clk);
            got = {i_gnt, d_gnt};
            exp = {(k % 4 == 0) && ((k / 4) % 2 == 0), (k % 4 == 0) && ((k / 4) % 2 == 1)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL round_robin k=%0d: got gnt(i,d)=%b want %b", k, got, exp);
            end
        end
    endtask
`else
    task automatic test_simultaneous();
        logic [5:0]  got, exp;
        logic [31:0] ea, eir, edr;
        @(posedge clk); #1;
        mem_force = 1'b1; mem_force_val = 32'h1111_2222;
        i_req = 1'b1; i_addr = 32'h200;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            if (k == 3) begin d_req = 1'b0; mem_force_val = 32'h3333_4444; end
            if (k == 7) i_req = 1'b0;
            @(negedge clk);
            got = {i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en, busy};
            exp = {k == 4, k == 0, k == 6, k == 2, (k <= 1) || (k == 4) || (k == 5), (k <= 2) || (k >= 4 && k <= 6)};
            ea  = (k <= 1) ? 32'h300 : ((k == 4 || k == 5) ? 32'h200 : 32'h0);
            eir = (k >= 6) ? 32'h3333_4444 : 32'hDEAD_BEEF;
            edr = (k >= 2) ? 32'h1111_2222 : 32'h0;
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL simultaneous_ctrl k=%0d: got %b want %b (gnt_i,gnt_d,rv_i,rv_d,en,busy)", k, got, exp);
            end
            checks++;
            if (mem_addr !== ea || i_rdata !== eir || d_rdata !== edr) begin
                errors++;
                $display("FAIL simultaneous_data k=%0d: got addr=%h ir=%h dr=%h want addr=%h ir=%h dr=%h",
                         k, mem_addr, i_rdata, d_rdata, ea, eir, edr);
            end
        end
        mem_force = 1'b0;
    endtask
`endif

    task automatic test_d_write();
        logic [5:0]  got, exp;
        logic [31:0] ea, ew;
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h1234_5678;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            // Request buses change after the grant; the access must not follow.
            if (k == 0) begin d_addr = 32'hFFFF_0000; d_wdata = 32'h0; end
            if (k == 3) begin d_req = 1'b0; d_we = 1'b0; end
            @(negedge clk);
            got = {d_gnt, mem_en, mem_we, d_rvalid, i_rvalid, busy};
            exp = {k == 0, k <= 1, k <= 1, k == 2, 1'b0, k <= 2};
            ea  = (k <= 1) ? 32'h40 : 32'h0;
            ew  = (k <= 1) ? 32'h1234_5678 : 32'h0;
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL d_write_ctrl k=%0d: got %b want %b (gnt_d,en,we,rv_d,rv_i,busy)", k, got, exp);
            end
            checks++;
            if (mem_addr !== ea || mem_wdata !== ew) begin
                errors++;
                $display("FAIL d_write_bus k=%0d: got addr=%h wdata=%h want addr=%h wdata=%h", k, mem_addr, mem_wdata, ea, ew);
            end
            if (k >= 2) begin
                checks++;
                if (d_rdata !== 32'h0) begin
                    errors++;
                    $display("FAIL d_write_rdata k=%0d: got %h want 00000000", k, d_rdata);
                end
            end
        end
    endtask

    task automatic test_reset_mid_access();
        @(posedge clk); #1;
        mem_force = 1'b1; mem_force_val = 32'h5555_AAAA;
        i_req = 1'b1; i_addr = 32'h80;
        @(posedge clk);            // grant edge
        @(posedge clk); #1;        // second access cycle
        checks++;
        if (mem_en !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_access_active: got en=%b busy=%b want 1 1", mem_en, busy);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({mem_en, busy, i_gnt, i_rvalid, mem_we, mem_addr} !== '0) begin
            errors++;
            $display("FAIL async_reset: got en=%b busy=%b gnt=%b rv=%b addr=%h want all 0",
                     mem_en, busy, i_gnt, i_rvalid, mem_addr);
        end
        i_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if ({i_rvalid, d_rvalid, busy} !== 3'b0) begin
                errors++;
                $display("FAIL abandoned_access k=%0d: got rv_i=%b rv_d=%b busy=%b want 0", k, i_rvalid, d_rvalid, busy);
            end
        end
        @(posedge clk); #1;
        mem_force_val = 32'hCAFE_F00D;
        i_req = 1'b1; i_addr = 32'h84;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (k == 3) i_req = 1'b0;
            @(negedge clk);
            checks++;
            if (i_rvalid !== (k == 2) || i_gnt !== (k == 0) ||
                i_rdata !== ((k >= 2) ? 32'hCAFE_F00D : 32'h0)) begin
                errors++;
                $display("FAIL post_reset_read k=%0d: got gnt=%b rv=%b rdata=%h want gnt=%b rv=%b rdata=%h",
                         k, i_gnt, i_rvalid, i_rdata, k == 0, k == 2, (k >= 2) ? 32'hCAFE_F00D : 32'h0);
            end
        end
        mem_force = 1'b0;
    endtask

    task automatic test_latency_sweep();
        int w1 = 0, w15 = 0, rv1 = -1, rv15 = -1, n1 = 0, n15 = 0;
        do_reset();
        mem_force = 1'b1; mem_force_val = 32'h0BAD_F00D;
        i_req = 1'b1; i_addr = 32'h500;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (k == 1) i_req = 1'b0;   // dropped mid-access: must still complete
            @(negedge clk);
            w1  += int'(s1_mem_en);
            w15 += int'(s15_mem_en);
            if (s1_i_rvalid)  begin rv1 = k;  n1++;  end
            if (s15_i_rvalid) begin rv15 = k; n15++; end
        end
        checks++;
        if (w1 != 1 || rv1 != 1 || n1 != 1) begin
            errors++;
            $display("FAIL lat1: got en_width=%0d rvalid_at=%0d pulses=%0d want 1 1 1", w1, rv1, n1);
        end
        checks++;
        if (w15 != 15 || rv15 != 15 || n15 != 1) begin
            errors++;
            $display("FAIL lat15: got en_width=%0d rvalid_at=%0d pulses=%0d want 15 15 1", w15, rv15, n15);
        end
        checks++;
        if (s1_i_rdata !== 32'h0BAD_F00D || s15_i_rdata !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL lat_rdata: got %h %h want 0badf00d", s1_i_rdata, s15_i_rdata);
        end
        mem_force = 1'b0;
    endtask

    // Randomized requesters; expectations come from the arbitration rules as
    // cycle arithmetic: a grant at edge s owns the port for cycles s..s+L-1,
    // responds in cycle s+L and the next grant can come at edge s+L+2.
    task automatic test_random(input int n);
        int          c, s, next_s, i_done, d_done;
        bit          tv, own_i, t_we, pick_i, last_i, acc;
        bit          i_pend, i_gr, d_pend, d_gr;
        logic [31:0] t_addr, t_wdata, i_exp, d_exp, e_addr, e_wdata;
        logic [6:0]  got, exp;
        do_reset();
        s = 0; next_s = 0; i_done = 0; d_done = 0; tv = 0; own_i = 0; t_we = 0; last_i = 0;
        i_pend = 0; i_gr = 0; d_pend = 0; d_gr = 0;
        t_addr = '0; t_wdata = '0; i_exp = '0; d_exp = '0;
        for (int it = 0; it < n; it++) begin
            @(posedge clk); #1;
            c = cyc;
            if (c >= next_s && (i_req || d_req)) begin
`ifdef ARB_ROUND_ROBIN_EN
                pick_i = i_req && (!d_req || !last_i);
                last_i = pick_i;
`else
                pick_i = i_req && !d_req;
`endif
                tv = 1; s = c; own_i = pick_i; next_s = c + L + 2;
                t_we    = pick_i ? 1'b0 : d_we;
                t_addr  = pick_i ? i_addr : d_addr;
                t_wdata = pick_i ? 32'h0 : d_wdata;
                if (pick_i) begin i_gr = 1; i_done = c + L; end
                else        begin d_gr = 1; d_done = c + L; end
            end
            if (tv && c == s + L) begin
                if (own_i) i_exp = mem_fn(t_addr, s + L - 1);
                else       d_exp = t_we ? 32'h0 : mem_fn(t_addr, s + L - 1);
            end
            // I requester
            if (i_pend && i_gr && c == i_done + 1) begin i_pend = 0; i_gr = 0; end
            if (!i_pend) begin
                i_addr = $urandom;
                if ($urandom_range(2) == 0) begin i_req = 1'b1; i_pend = 1; end
                else i_req = 1'b0;
            end else if (i_gr) begin
                i_addr = $urandom;
                if ($urandom_range(7) == 0) i_req = 1'b0;
            end
            // D requester
            if (d_pend && d_gr && c == d_done + 1) begin d_pend = 0; d_gr = 0; end
            if (!d_pend) begin
                d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom_range(1));
                if ($urandom_range(2) == 0) begin d_req = 1'b1; d_pend = 1; end
                else d_req = 1'b0;
            end else if (d_gr) begin
                d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom_range(1));
                if ($urandom_range(7) == 0) d_req = 1'b0;
            end
            @(negedge clk);
            acc     = tv && c >= s && c <= s + L - 1;
            e_addr  = acc ? t_addr : 32'h0;
            e_wdata = acc ? t_wdata : 32'h0;
            got = {i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en, mem_we, busy};
            exp = {tv && c == s && own_i, tv && c == s && !own_i, tv && c == s + L && own_i,
                   tv && c == s + L && !own_i, acc, acc && t_we, tv && c >= s && c <= s + L};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random_ctrl cyc=%0d: got %b want %b (gnt_i,gnt_d,rv_i,rv_d,en,we,busy)", c, got, exp);
            end
            checks++;
            if (mem_addr !== e_addr || mem_wdata !== e_wdata) begin
                errors++;
                $display("FAIL random_bus cyc=%0d: got addr=%h wdata=%h want addr=%h wdata=%h",
                         c, mem_addr, mem_wdata, e_addr, e_wdata);
            end
            checks++;
            if (i_rdata !== i_exp || d_rdata !== d_exp) begin
                errors++;
                $display("FAIL random_rdata cyc=%0d: got i=%h d=%h want i=%h d=%h", c, i_rdata, d_rdata, i_exp, d_exp);
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        repeat (L + 3) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_single_i_read();
`ifdef ARB_ROUND_ROBIN_EN
        test_round_robin();
`else
        test_simultaneous();
`endif
        test_d_write();
        test_reset_mid_access();
        test_latency_sweep();
        test_random(800);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
